mul_pp_gen_stage: RTL and testbench

Pipelined partial-product generation stage of the integer multiply functional unit, sitting directly upstream of the carry-save reduction tree. Accepts two N-bit operands with per-operand signedness (covering MUL/MULH/MULHSU/MULHU), and produces N rows of 2N bits whose modulo-2^2N sum equals the exact product. Rows are registered behind a two-entry skid buffer with valid/ready handshakes, so backpressure from the reduction/final-add path never creates a combinational ready path.

---
 rtl/mul_pp_gen_stage.sv | 134 +++++++++++++
 tb/tb_mul_pp_gen_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_pp_gen_stage.sv
// Partial-product generation stage of the integer multiplier: N rows of 2N bits
// per operand pair, registered behind a two-entry skid buffer.
module mul_pp_gen_stage #(
  parameter int unsigned N    = 32,
  parameter int unsigned TAGW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      op_a,
  input  logic [N-1:0]      op_b,
  input  logic              a_signed,
  input  logic              b_signed,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*N-1:0]    pp [N],
  output logic              out_zero,
  output logic [TAGW-1:0]   out_tag
);

  localparam int unsigned W = 2 * N;

  typedef struct packed {
    logic [N-1:0][W-1:0] rows;
    logic                zero;
    logic [TAGW-1:0]     tag;
  } beat_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t        state_q, state_d;
  beat_t         in_beat_c, out_q, skid_q;
  logic [W-1:0]  a_ext_c;
  logic          accept_c, drain_c;
  logic          load_out_c, load_skid_c, pop_skid_c;

  // Row generation; the top row carries weight -2^(N-1) when op_b is signed.
  always_comb begin
    a_ext_c   = a_signed ? {{N{op_a[N-1]}}, op_a} : {{N{1'b0}}, op_a};
    in_beat_c = '0;
    for (int i = 0; i < N - 1; i++) begin
      in_beat_c.rows[i] = op_b[i] ? (a_ext_c << i) : '0;
    end
    if (op_b[N-1]) begin
      in_beat_c.rows[N-1] = b_signed ? (~(a_ext_c << (N - 1))) + W'(1)
                                     : (a_ext_c << (N - 1));
    end
    in_beat_c.zero = (op_a == '0) | (op_b == '0);
    in_beat_c.tag  = in_tag;
  end

  assign accept_c = in_valid & in_ready;
  assign drain_c  = out_valid & out_ready;

  // Next-state and buffer-steering decode.
  always_comb begin
    state_d     = state_q;
    load_out_c  = 1'b0;
    load_skid_c = 1'b0;
    pop_skid_c  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept_c) begin
          state_d    = ONE;
          load_out_c = 1'b1;
        end
      end
      ONE: begin
        if (accept_c && drain_c) begin
          load_out_c = 1'b1;
        end else if (accept_c) begin
          state_d     = FULL;
          load_skid_c = 1'b1;
        end else if (drain_c) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain_c) begin
          state_d    = ONE;
          pop_skid_c = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d     = EMPTY;
      load_out_c  = 1'b0;
      load_skid_c = 1'b0;
      pop_skid_c  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d != FULL);
      out_valid <= (state_d != EMPTY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out_c) begin
        out_q <= in_beat_c;
      end else if (pop_skid_c) begin
        out_q <= skid_q;
      end
      if (load_skid_c) begin
        skid_q <= in_beat_c;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pp[i] = out_q.rows[i];
    end
  end

  assign out_zero = out_q.zero;
  assign out_tag  = out_q.tag;

endmodule

// File: tb/tb_mul_pp_gen_stage.sv
// Scoreboard bench for mul_pp_gen_stage: reference products are queued on
// accept and compared against the row sum when the beat drains.
module tb_mul_pp_gen_stage;

  localparam int unsigned N    = 32;
  localparam int unsigned TAGW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N-1:0]    op_a = '0;
  logic [N-1:0]    op_b = '0;
  logic            a_signed = 1'b0;
  logic            b_signed = 1'b0;
  logic [TAGW-1:0] in_tag = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2*N-1:0]  pp [N];
  logic            out_zero;
  logic [TAGW-1:0] out_tag;

  typedef struct {
    logic [2*N-1:0]  prod;
    logic            zero;
    logic [TAGW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mul_pp_gen_stage #(.N(N), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .a_signed(a_signed), .b_signed(b_signed),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .pp(pp), .out_zero(out_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input logic as, input logic bs);
    logic [2*N-1:0] ax, bx;
    ax = as ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
    bx = bs ? {{N{b[N-1]}}, b} : {{N{1'b0}}, b};
    return ax * bx;
  endfunction

  // Scoreboard: pop/compare on drain, push on accept (both sampled mid-cycle).
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        logic [2*N-1:0] sum;
        exp_t e;
        sum = '0;
        for (int i = 0; i < N; i++) sum = sum + pp[i];
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got tag %0d, expected no beat", out_tag);
        end else begin
          e = sb.pop_front();
          if (sum !== e.prod || out_zero !== e.zero || out_tag !== e.tag) begin
            errors++;
            $display("FAIL beat: got sum %h zero %b tag %0d, expected sum %h zero %b tag %0d",
                     sum, out_zero, out_tag, e.prod, e.zero, e.tag);
          end
          if (e.zero) begin
            logic any_set;
            any_set = 1'b0;
            for (int i = 0; i < N; i++) if (pp[i] != '0) any_set = 1'b1;
            checks++;
            if (any_set !== 1'b0) begin
              errors++;
              $display("FAIL zero_rows: got nonzero row, expected all rows 0 (tag %0d)", out_tag);
            end
          end
        end
      end
      if (in_valid && in_ready && !flush) begin
        exp_t e;
        e.prod = ref_prod(op_a, op_b, a_signed, b_signed);
        e.zero = (op_a == '0) || (op_b == '0);
        e.tag  = in_tag;
        sb.push_back(e);
      end
    end
  end

  task automatic wait_accept(input string name);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got in_ready 0 for 50 cycles, expected accept", name);
    end
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic as,
                      input logic bs, input logic [TAGW-1:0] tag);
    op_a = a; op_b = b; a_signed = as; b_signed = bs; in_tag = tag;
    in_valid = 1'b1;
    wait_accept("send");
  endtask

  task automatic wait_empty(input string name);
    for (int n = 0; n < 20 && (sb.size() != 0 || out_valid); n++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending, out_valid %b, expected 0 pending", name,
               sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_tag !== '0 || out_zero !== 1'b0 ||
        pp[0] !== '0 || pp[N-1] !== '0) begin
      errors++;
      $display("FAIL reset_state: got out_valid %b in_ready %b tag %0d zero %b, expected all 0",
               out_valid, in_ready, out_tag, out_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready %b out_valid %b, expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_unsigned();
    out_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd1);
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 5'd1) begin
      errors++;
      $display("FAIL latency: got out_valid %b tag %0d, expected 1 tag 1", out_valid, out_tag);
    end
    checks++;
    if (ref_prod(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0) !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL ref_unsigned: got %h, expected fffffffe00000001",
               ref_prod(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0));
    end
    send(32'h0000_1234, 32'h0000_0003, 1'b0, 1'b0, 5'd2);
    wait_empty("unsigned");
  endtask

  task automatic test_signed();
    out_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd3);
    send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 5'd4);
    send(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 5'd5);
    checks++;
    if (ref_prod(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1) !== 64'h4000_0000_0000_0000) begin
      errors++;
      $display("FAIL ref_signed: got %h, expected 4000000000000000",
               ref_prod(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1));
    end
    wait_empty("signed");
  endtask

  task automatic test_mulhsu();
    out_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd6);
    checks++;
    if (ref_prod(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0) !== 64'hFFFF_FFFF_0000_0001) begin
      errors++;
      $display("FAIL ref_mulhsu: got %h, expected ffffffff00000001",
               ref_prod(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0));
    end
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 5'd7);
    checks++;
    if (out_zero !== 1'b1) begin
      errors++;
      $display("FAIL out_zero: got %b, expected 1", out_zero);
    end
    send(32'h0000_0000, 32'h8000_0001, 1'b0, 1'b1, 5'd8);
    wait_empty("mulhsu");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send(32'd11, 32'd3, 1'b0, 1'b0, 5'd1);
    send(32'd12, 32'd5, 1'b0, 1'b0, 5'd2);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd1) begin
      errors++;
      $display("FAIL full: got in_ready %b out_valid %b tag %0d, expected 0 1 1",
               in_ready, out_valid, out_tag);
    end
    op_a = 32'd13; op_b = 32'd7; a_signed = 1'b0; b_signed = 1'b0; in_tag = 5'd3;
    in_valid = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_tag !== 5'd1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold: got tag %0d in_ready %b, expected tag 1 in_ready 0", out_tag, in_ready);
      end
    end
    out_ready = 1'b1;
    wait_accept("bp");
    wait_empty("backpressure");
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready: got in_ready %b, expected 1", in_ready);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'd21, 32'd2, 1'b0, 1'b0, 5'd5);
    send(32'd22, 32'd2, 1'b0, 1'b0, 5'd6);
    op_a = 32'd23; op_b = 32'd2; in_tag = 5'd7;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush: got out_valid %b in_ready %b, expected 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(32'd9, 32'd9, 1'b0, 1'b0, 5'd10);
    wait_empty("flush");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(32'd31, 32'd4, 1'b0, 1'b0, 5'd8);
    send(32'd32, 32'd4, 1'b0, 1'b0, 5'd9);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_tag !== '0) begin
      errors++;
      $display("FAIL async_reset: got out_valid %b in_ready %b tag %0d, expected 0 0 0",
               out_valid, in_ready, out_tag);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: got in_ready %b out_valid %b, expected 1 0",
               in_ready, out_valid);
    end
    out_ready = 1'b1;
    send(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b0, 5'd11);
    wait_empty("reset_mid");
  endtask

  task automatic test_random();
    for (int k = 0; k < 10000; k++) begin
      logic acc;
      op_a     = $urandom;
      op_b     = $urandom;
      if ($urandom_range(0, 15) == 0) op_a = '0;
      if ($urandom_range(0, 15) == 0) op_b = '0;
      a_signed = 1'($urandom_range(0, 1));
      b_signed = 1'($urandom_range(0, 1));
      in_tag   = TAGW'(k);
      in_valid = 1'b1;
      acc = 1'b0;
      for (int n = 0; n < 50 && !acc; n++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL random_timeout: got no accept for beat %0d, expected accept", k);
        break;
      end
    end
    out_ready = 1'b1;
    wait_empty("random");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_mulhsu();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
